// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit Tron core: latches each instruction,
// drives register file / ALU / memory controls and issues one PC command per instruction.
//
// state  | meaning
// FETCH  | latch instruction from memory (PC-addressed)
// DECODE | register addresses, ALU op and immediate valid
// EXEC   | ALU op; STOR write; flag-only compare write
// MEM    | wait for LOAD data (memReady)
// WB     | register / flag write-back
// PCUPD  | evaluate condition, issue exactly one PC command
module control_fsm #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memReady,
  input  logic [WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0] flagRegister,
  input  logic [WIDTH-1:0] regAData,
  output logic [WIDTH-1:0] instrReg,
  output logic [3:0]       regA,
  output logic [3:0]       regB,
  output logic [3:0]       aluOp,
  output logic             immSelect,
  output logic [WIDTH-1:0] immediate,
  output logic [3:0]       flagOp,
  output logic             regWrite,
  output logic             flagWrite,
  output logic             memWrite,
  output logic             memAddrSel,
  output logic             pcAdd,
  output logic             pcBranch,
  output logic             pcJump,
  output logic [2:0]       state
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] PCUPD  = 3'd5;

  logic [2:0]       next_state;
  logic [WIDTH-1:0] jump_target;
  logic [3:0]       opcode;
  logic [3:0]       ext;
  logic [3:0]       cond;
  logic [WIDTH-1:0] sext_imm;
  logic [WIDTH-1:0] zext_imm;

  logic             wb_reg;
  logic             wb_flag;
  logic             exec_flag;
  logic             is_load;
  logic             is_stor;
  logic             is_jump;
  logic             is_branch;
  logic             imm_sel;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] imm_ext;
  logic             taken;
  logic             unused_flags;

  assign opcode   = instrReg[15:12];
  assign ext      = instrReg[7:4];
  assign cond     = instrReg[11:8];
  assign sext_imm = {{(WIDTH-8){instrReg[7]}}, instrReg[7:0]};
  assign zext_imm = {{(WIDTH-8){1'b0}}, instrReg[7:0]};

  assign unused_flags = ^flagRegister[WIDTH-1:5];

  always_comb begin
    wb_reg    = 1'b0;
    wb_flag   = 1'b0;
    exec_flag = 1'b0;
    is_load   = 1'b0;
    is_stor   = 1'b0;
    is_jump   = 1'b0;
    is_branch = 1'b0;
    imm_sel   = 1'b0;
    alu_op    = 4'd0;
    imm_ext   = '0;
    case (opcode)
      4'b0000: begin
        alu_op = ext;
        if (ext == 4'b1011) begin
          exec_flag = 1'b1;
        end else begin
          wb_reg  = 1'b1;
          wb_flag = 1'b1;
        end
      end
      4'b0101, 4'b1001: begin
        alu_op  = opcode;
        imm_sel = 1'b1;
        imm_ext = sext_imm;
        wb_reg  = 1'b1;
        wb_flag = 1'b1;
      end
      4'b1011: begin
        alu_op    = opcode;
        imm_sel   = 1'b1;
        imm_ext   = sext_imm;
        exec_flag = 1'b1;
      end
      4'b0001, 4'b0010, 4'b0011, 4'b1101: begin
        alu_op  = opcode;
        imm_sel = 1'b1;
        imm_ext = zext_imm;
        wb_reg  = 1'b1;
      end
      4'b0100: begin
        case (ext)
          4'b0000: is_load = 1'b1;
          4'b0100: is_stor = 1'b1;
          4'b1100: is_jump = 1'b1;
          default: ;
        endcase
      end
      4'b1100: begin
        is_branch = 1'b1;
        imm_ext   = sext_imm;
      end
      default: ;
    endcase
  end

  function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn;
    fc = f[0];
    fl = f[1];
    ff = f[2];
    fz = f[3];
    fn = f[4];
    case (c)
      4'b0000: cond_true = fz;
      4'b0001: cond_true = !fz;
      4'b0010: cond_true = fc;
      4'b0011: cond_true = !fc;
      4'b0100: cond_true = fl;
      4'b0101: cond_true = !fl;
      4'b0110: cond_true = fn;
      4'b0111: cond_true = !fn;
      4'b1000: cond_true = ff;
      4'b1001: cond_true = !ff;
      4'b1010: cond_true = !fl && !fz;
      4'b1011: cond_true = fl || fz;
      4'b1100: cond_true = !fn && !fz;
      4'b1101: cond_true = fn || fz;
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

  assign taken = cond_true(cond, flagRegister[4:0]);

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: next_state = EXEC;
      EXEC: begin
        if (is_load)     next_state = MEM;
        else if (wb_reg) next_state = WB;
        else             next_state = PCUPD;
      end
      MEM:     next_state = memReady ? WB : MEM;
      WB:      next_state = PCUPD;
      PCUPD:   next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FETCH;
      instrReg    <= '0;
      jump_target <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH)  instrReg    <= instruction;
      if (state == DECODE) jump_target <= regAData;
    end
  end

  // Jump target is read live in DECODE, then held so it cannot drift before PCUPD.
  assign immediate  = is_jump ? ((state == DECODE) ? regAData : jump_target) : imm_ext;
  assign regA       = is_jump ? instrReg[3:0] : instrReg[11:8];
  assign regB       = instrReg[3:0];
  assign aluOp      = alu_op;
  assign immSelect  = imm_sel;
  assign flagOp     = (is_jump || is_branch) ? cond : 4'd0;

  assign memAddrSel = (is_load && (state == EXEC || state == MEM)) || (is_stor && state == EXEC);
  assign memWrite   = is_stor && (state == EXEC);
  assign regWrite   = (state == WB) && (wb_reg || is_load);
  assign flagWrite  = ((state == WB) && wb_flag) || ((state == EXEC) && exec_flag);

  assign pcBranch   = (state == PCUPD) && is_branch && taken;
  assign pcJump     = (state == PCUPD) && is_jump && taken;
  assign pcAdd      = (state == PCUPD) && !(is_branch && taken) && !(is_jump && taken);

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: stimulus queues per-instruction expectations,
// a negedge monitor scores each instruction when it reaches PCUPD or is abandoned.
module tb_control_fsm;

  logic        clk;
  logic        reset;
  logic        memReady;
  logic [15:0] instruction;
  logic [15:0] flagRegister;
  logic [15:0] regAData;
  logic [15:0] instrReg;
  logic [3:0]  regA;
  logic [3:0]  regB;
  logic [3:0]  aluOp;
  logic        immSelect;
  logic [15:0] immediate;
  logic [3:0]  flagOp;
  logic        regWrite;
  logic        flagWrite;
  logic        memWrite;
  logic        memAddrSel;
  logic        pcAdd;
  logic        pcBranch;
  logic        pcJump;
  logic [2:0]  state;

  control_fsm #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .memReady(memReady), .instruction(instruction),
    .flagRegister(flagRegister), .regAData(regAData), .instrReg(instrReg),
    .regA(regA), .regB(regB), .aluOp(aluOp), .immSelect(immSelect),
    .immediate(immediate), .flagOp(flagOp), .regWrite(regWrite),
    .flagWrite(flagWrite), .memWrite(memWrite), .memAddrSel(memAddrSel),
    .pcAdd(pcAdd), .pcBranch(pcBranch), .pcJump(pcJump), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] PC_ADD = 3'b001;
  localparam logic [2:0] PC_BR  = 3'b010;
  localparam logic [2:0] PC_JMP = 3'b100;

  typedef struct {
    int          tag;
    bit          abort;
    logic [2:0]  pc;
    int          cycles;
    int          rw;
    int          fw;
    int          mw;
    int          mas;
    logic [15:0] imm;
    logic [3:0]  fop;
    logic [3:0]  alu;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        isel;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   next_tag = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          rw_pos, fw_pos, mw_pos, mas_cnt, pc_extra, wr_cnt;
  logic [15:0] imm_dec;
  logic [3:0]  fop_dec, alu_dec, ra_dec, rb_dec;
  logic        isel_dec;
  logic [2:0]  prev_state = 3'd0;

  always @(negedge clk) begin
    exp_t e;
    if (state == 3'd0) begin
      if (prev_state != 3'd0 && prev_state != 3'd5) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_abandon", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("i%0d_abandon_kind", e.tag), e.abort, 1);
          chk($sformatf("i%0d_abandon_writes", e.tag), wr_cnt, 0);
          chk($sformatf("i%0d_abandon_pc", e.tag), pc_extra, 0);
        end
      end
      cyc = 1;
      rw_pos = 0; fw_pos = 0; mw_pos = 0; mas_cnt = 0; pc_extra = 0; wr_cnt = 0;
    end else begin
      cyc++;
    end
    if (regWrite)  begin wr_cnt++; rw_pos = (rw_pos == 0) ? cyc : 99; end
    if (flagWrite) begin wr_cnt++; fw_pos = (fw_pos == 0) ? cyc : 99; end
    if (memWrite)  begin wr_cnt++; mw_pos = (mw_pos == 0) ? cyc : 99; end
    if (memAddrSel) mas_cnt++;
    if (state != 3'd5 && (pcAdd || pcBranch || pcJump)) pc_extra++;
    if (cyc == 2) begin
      imm_dec = immediate; fop_dec = flagOp; alu_dec = aluOp;
      ra_dec = regA; rb_dec = regB; isel_dec = immSelect;
    end
    if (state == 3'd5) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pc_update", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("i%0d_kind", e.tag), e.abort, 0);
        chk($sformatf("i%0d_pc_cmd", e.tag), {pcJump, pcBranch, pcAdd}, e.pc);
        chk($sformatf("i%0d_cycles", e.tag), cyc, e.cycles);
        chk($sformatf("i%0d_regWrite_cycle", e.tag), rw_pos, e.rw);
        chk($sformatf("i%0d_flagWrite_cycle", e.tag), fw_pos, e.fw);
        chk($sformatf("i%0d_memWrite_cycle", e.tag), mw_pos, e.mw);
        chk($sformatf("i%0d_memAddrSel_cycles", e.tag), mas_cnt, e.mas);
        chk($sformatf("i%0d_pc_outside_pcupd", e.tag), pc_extra, 0);
        chk($sformatf("i%0d_imm_decode", e.tag), imm_dec, e.imm);
        chk($sformatf("i%0d_imm_pcupd", e.tag), immediate, e.imm);
        chk($sformatf("i%0d_flagOp_decode", e.tag), fop_dec, e.fop);
        chk($sformatf("i%0d_flagOp_pcupd", e.tag), flagOp, e.fop);
        chk($sformatf("i%0d_dec_fields", e.tag), {alu_dec, ra_dec, rb_dec, 3'b000, isel_dec},
            {e.alu, e.ra, e.rb, 3'b000, e.isel});
      end
    end
    prev_state = state;
  end

  // ---------------- stimulus ----------------
  task automatic wait_fetch(input string nm);
    for (int i = 0; i < 40 && state != 3'd0; i++) @(negedge clk);
    chk({nm, "_reach_fetch"}, (state == 3'd0), 1);
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] flags, input logic [15:0] rad,
                       input int wait_cycles, input logic [2:0] pc, input int cycles,
                       input int rw, input int fw, input int mw, input int mas,
                       input logic [15:0] imm, input logic [3:0] fop, input logic [3:0] alu,
                       input logic [3:0] ra, input logic [3:0] rb, input logic isel);
    exp_t e;
    int   mem_k;
    bit   done;
    e.tag = next_tag++; e.abort = 1'b0; e.pc = pc; e.cycles = cycles;
    e.rw = rw; e.fw = fw; e.mw = mw; e.mas = mas; e.imm = imm; e.fop = fop;
    e.alu = alu; e.ra = ra; e.rb = rb; e.isel = isel;
    wait_fetch($sformatf("i%0d", e.tag));
    exp_q.push_back(e);
    instruction  = ins;
    flagRegister = flags;
    regAData     = rad;
    memReady     = 1'b1;
    mem_k = 0;
    done  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      // Past DECODE the jump target must already be held inside the controller.
      if (state == 3'd2) begin
        regAData = ~rad;
        if (wait_cycles > 0) memReady = 1'b0;
      end
      if (state == 3'd3) begin
        mem_k++;
        if (mem_k > wait_cycles) memReady = 1'b1;
      end
      if (state == 3'd5) begin
        done = 1'b1;
        break;
      end
    end
    chk($sformatf("i%0d_completed", e.tag), done, 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_state"}, state, 0);
    chk({nm, "_instrReg"}, instrReg, 0);
    chk({nm, "_immediate"}, immediate, 0);
    chk({nm, "_fields"}, {flagOp, aluOp, regA, regB}, 0);
    chk({nm, "_strobes"}, {immSelect, memAddrSel, regWrite, flagWrite, memWrite,
                           pcAdd, pcBranch, pcJump}, 0);
  endtask

  task automatic abort_load();
    exp_t e;
    e = '{tag: next_tag++, abort: 1'b1, pc: 3'b000, cycles: 0, rw: 0, fw: 0, mw: 0, mas: 0,
          imm: 16'h0, fop: 4'h0, alu: 4'h0, ra: 4'h0, rb: 4'h0, isel: 1'b0};
    wait_fetch("abort");
    exp_q.push_back(e);
    instruction  = 16'h4203;
    flagRegister = 16'h0000;
    regAData     = 16'h0000;
    memReady     = 1'b0;
    for (int i = 0; i < 20 && state != 3'd3; i++) @(negedge clk);
    chk("abort_reach_mem", state, 3);
    repeat (2) @(negedge clk);
    chk("abort_still_mem", state, 3);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort_rst");
    instruction = 16'hF000;
    memReady    = 1'b1;
    reset       = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    memReady     = 1'b1;
    instruction  = 16'h0000;
    flagRegister = 16'h0000;
    regAData     = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    //    instr     flags     regAData  wait pc      cyc rw fw mw mas imm       fop   alu   ra    rb    isel
    issue(16'h0152, 16'h0000, 16'h0000, 0, PC_ADD, 5, 4, 4, 0, 0, 16'h0000, 4'h0, 4'h5, 4'h1, 4'h2, 1'b0);
    issue(16'h03B4, 16'h0000, 16'h0000, 0, PC_ADD, 4, 0, 3, 0, 0, 16'h0000, 4'h0, 4'hB, 4'h3, 4'h4, 1'b0);
    issue(16'h57F0, 16'h0000, 16'h0000, 0, PC_ADD, 5, 4, 4, 0, 0, 16'hFFF0, 4'h0, 4'h5, 4'h7, 4'h0, 1'b1);
    issue(16'h2A85, 16'h0000, 16'h0000, 0, PC_ADD, 5, 4, 0, 0, 0, 16'h0085, 4'h0, 4'h2, 4'hA, 4'h5, 1'b1);
    issue(16'hB27F, 16'h0000, 16'h0000, 0, PC_ADD, 4, 0, 3, 0, 0, 16'h007F, 4'h0, 4'hB, 4'h2, 4'hF, 1'b1);
    issue(16'h4546, 16'h0000, 16'h0000, 0, PC_ADD, 4, 0, 0, 3, 1, 16'h0000, 4'h0, 4'h0, 4'h5, 4'h6, 1'b0);
    issue(16'hC0FD, 16'h0008, 16'h0000, 0, PC_BR,  4, 0, 0, 0, 0, 16'hFFFD, 4'h0, 4'h0, 4'h0, 4'hD, 1'b0);
    issue(16'hC0FD, 16'h0000, 16'h0000, 0, PC_ADD, 4, 0, 0, 0, 0, 16'hFFFD, 4'h0, 4'h0, 4'h0, 4'hD, 1'b0);
    issue(16'hCA10, 16'h0001, 16'h0000, 0, PC_BR,  4, 0, 0, 0, 0, 16'h0010, 4'hA, 4'h0, 4'hA, 4'h0, 1'b0);
    issue(16'hCC05, 16'h0010, 16'h0000, 0, PC_ADD, 4, 0, 0, 0, 0, 16'h0005, 4'hC, 4'h0, 4'hC, 4'h5, 1'b0);
    issue(16'hCB02, 16'h0002, 16'h0000, 0, PC_BR,  4, 0, 0, 0, 0, 16'h0002, 4'hB, 4'h0, 4'hB, 4'h2, 1'b0);
    issue(16'hC301, 16'h0001, 16'h0000, 0, PC_ADD, 4, 0, 0, 0, 0, 16'h0001, 4'h3, 4'h0, 4'h3, 4'h1, 1'b0);
    issue(16'hC8FF, 16'h0004, 16'h0000, 0, PC_BR,  4, 0, 0, 0, 0, 16'hFFFF, 4'h8, 4'h0, 4'h8, 4'hF, 1'b0);
    issue(16'h4EC3, 16'h0000, 16'h0040, 0, PC_JMP, 4, 0, 0, 0, 0, 16'h0040, 4'hE, 4'h0, 4'h3, 4'h3, 1'b0);
    issue(16'h4FC1, 16'h001F, 16'h1234, 0, PC_ADD, 4, 0, 0, 0, 0, 16'h1234, 4'hF, 4'h0, 4'h1, 4'h1, 1'b0);
    issue(16'h41C2, 16'h0000, 16'hBEEF, 0, PC_JMP, 4, 0, 0, 0, 0, 16'hBEEF, 4'h1, 4'h0, 4'h2, 4'h2, 1'b0);
    issue(16'h4203, 16'h0000, 16'h0000, 3, PC_ADD, 9, 8, 0, 0, 5, 16'h0000, 4'h0, 4'h0, 4'h2, 4'h3, 1'b0);
    issue(16'h4807, 16'h0000, 16'h0000, 0, PC_ADD, 6, 5, 0, 0, 2, 16'h0000, 4'h0, 4'h0, 4'h8, 4'h7, 1'b0);
    issue(16'hF000, 16'h0000, 16'h0000, 0, PC_ADD, 4, 0, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    abort_load();
    issue(16'h0152, 16'h0000, 16'h0000, 0, PC_ADD, 5, 4, 4, 0, 0, 16'h0000, 4'h0, 4'h5, 4'h1, 4'h2, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle fetch/decode/execute controller for the 16-bit Tron core. It latches each instruction from memory and sequences the register file, ALU, flag register and data memory. It then issues exactly one program-counter update command per instruction on pcAdd, pcBranch or pcJump, together with flagOp and immediate. Branch and jump conditions are evaluated here, so the program counter only ever receives a command when it must change.

## Interface
- WIDTH, 16, datapath/instruction width; all logic below assumes 16.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- memReady  in  1  data memory read data valid (LOAD handshake).
- instruction  in  WIDTH  memory read data, valid during FETCH.
- flagRegister  in  WIDTH  flags: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
- regAData  in  WIDTH  register-file port A read data (jump target).
- instrReg  out  WIDTH  latched instruction.
- regA, regB  out  4  register-file read addresses.
- aluOp  out  4  ALU operation select.
- immSelect  out  1  1 = ALU operand B is immediate.
- immediate  out  WIDTH  extended immediate / branch displacement / jump target.
- flagOp  out  4  condition code to program counter (= instrReg[11:8] for branch/jump, else 0).
- regWrite, flagWrite, memWrite  out  1  one-cycle write strobes.
- memAddrSel  out  1  0 = memory addressed by PC, 1 = by regB data (LOAD/STOR).
- pcAdd, pcBranch, pcJump  out  1  mutually exclusive one-cycle PC commands.
- state  out  3  current state (debug).

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, PCUPD=5. Encodings 6 and 7 go to FETCH.
- FETCH: instrReg <= instruction; memAddrSel=0; -> DECODE.
- DECODE: drive regA=instrReg[11:8], regB=instrReg[3:0], aluOp, immSelect, immediate; -> EXEC.
- Encoding (opcode = instrReg[15:12]):
  - 0000 R-type: aluOp=instrReg[7:4], immSelect=0. CMP (ext 1011) asserts flagWrite only; all others assert regWrite and flagWrite.
  - 0101 ADDI, 1001 SUBI, 1011 CMPI: immediate = sign-extend instrReg[7:0], aluOp=opcode, immSelect=1. CMPI asserts flagWrite only.
  - 0001 ANDI, 0010 ORI, 0011 XORI, 1101 MOVI: immediate = zero-extend instrReg[7:0]; regWrite only.
  - 0100 ext 0000 LOAD: memAddrSel=1 in EXEC and MEM; regWrite in WB.
  - 0100 ext 0100 STOR: memAddrSel=1 and memWrite pulse in EXEC.
  - 0100 ext 1100 Jcond: cond=instrReg[11:8], regA=instrReg[3:0], immediate=regAData.
  - 1100 Bcond: cond=instrReg[11:8], immediate = sign-extend instrReg[7:0].
  - Any other opcode/ext: NOP, no strobes.
- Transitions:
  - ALU ops: EXEC -> WB -> PCUPD.
  - LOAD: EXEC -> MEM; MEM holds until memReady=1; then -> WB -> PCUPD.
  - STOR, branch, jump, NOP: EXEC -> PCUPD.
  - PCUPD -> FETCH.
- Condition evaluation in PCUPD, from flagRegister sampled that cycle:
  - EQ 0000 Z; NE 0001 !Z.
  - CS 0010 C; CC 0011 !C.
  - HI 0100 L; LS 0101 !L.
  - GT 0110 N; LE 0111 !N.
  - FS 1000 F; FC 1001 !F.
  - LO 1010 !L&!Z; HS 1011 L|Z.
  - LT 1100 !N&!Z; GE 1101 N|Z.
  - UC 1110 true; 1111 false.
- PC command in PCUPD:
  - Bcond taken: pcBranch=1.
  - Jcond taken: pcJump=1.
  - Everything else, including not-taken: pcAdd=1.
- regWrite/flagWrite only in WB (flag-only ops: flagWrite in EXEC, then -> PCUPD).

## Timing
- All outputs registered or decoded from registered state/instrReg. No combinational path from flagRegister to state.
- Cycles per instruction:
  - ALU: 5.
  - STOR / branch / jump / NOP: 4.
  - LOAD: 6 + (cycles memReady low in MEM).
- Exactly one PC strobe per instruction, high for exactly one cycle. All three strobes are 0 in every other state.
- immediate and flagOp are stable from DECODE through PCUPD inclusive.
- Reset (reset=0 at a rising edge, any state, including MEM wait):
  - next state = FETCH; instrReg=0.
  - all strobes 0; immediate=0, flagOp=0, aluOp=0, regA=regB=0, immSelect=0, memAddrSel=0.
  - An in-flight instruction is abandoned with no write or PC strobe.
- memReady is ignored outside MEM. memReady=1 on MEM entry costs zero wait cycles.

## Test plan
- Reset: hold reset=0 for 2 cycles, release -> state=0, all strobes 0. After release: FETCH, DECODE, … sequence; first pcAdd 4–5 cycles later.
- R-type ADD 0x0152 -> aluOp=5, regA=1, regB=2. regWrite and flagWrite in cycle 4, pcAdd in cycle 5, no other strobe.
- Bcond EQ 0xC0FD:
  - Z=1 -> pcBranch=1, flagOp=0, immediate=0xFFFD.
  - Z=0 -> pcAdd=1 instead.
- Jcond UC 0x4EC3 with regAData=0x0040 -> regA=3, immediate=0x0040, pcJump pulse in cycle 4. Jcond cond 1111 -> pcAdd.
- LOAD 0x4203 with memReady low 3 cycles -> state stays 3 for 3 cycles, memAddrSel=1 throughout. Then regWrite in WB, pcAdd; total 9 cycles.
- Reset asserted during MEM wait -> FETCH next cycle, no regWrite and no PC strobe for the abandoned LOAD. Illegal opcode 0xF000 -> 4 cycles, pcAdd only.
